// File: rtl/ofdm_rx_pkg.sv
// Shared constants, read-FSM state type and index helpers for the OFDM receive path.
package ofdm_rx_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int N_FFT      = 64;
  localparam int ADDR_WIDTH = $clog2(N_FFT);

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } r_state_t;

  function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      r[i] = a[ADDR_WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/symbol_pingpong_ram.sv
// Two-bank symbol store: synchronous write port, asynchronous read port.
// Contents are never reset; occupancy is tracked by the framer, not here.
module symbol_pingpong_ram #(
  parameter int DATA_WIDTH = ofdm_rx_pkg::DATA_WIDTH,
  parameter int N_FFT      = ofdm_rx_pkg::N_FFT,
  parameter int ADDR_WIDTH = ofdm_rx_pkg::ADDR_WIDTH
) (
  input  logic                    CLK,
  input  logic                    we,
  input  logic                    wr_bank,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_bank,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [2*DATA_WIDTH-1:0] rd_data
);

  logic [2*DATA_WIDTH-1:0] mem [2][N_FFT];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/ofdm_symbol_framer.sv
// Packs sync-long samples into 64-sample symbols (ping-pong) and streams them to the FFT.
// Build option: OFDM_FRAMER_BIT_REVERSE_EN delivers each symbol in bit-reversed order.
//
//   state    | meaning
//   R_IDLE   | no complete symbol buffered, out_valid low
//   R_STREAM | presenting bank[rbank] sample by sample to the FFT
module ofdm_symbol_framer #(
  parameter int DATA_WIDTH = ofdm_rx_pkg::DATA_WIDTH,
  parameter int N_FFT      = ofdm_rx_pkg::N_FFT,
  parameter int ADDR_WIDTH = ofdm_rx_pkg::ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  s_RST,
  input  logic                  in_strobe,
  input  logic                  in_providing_long,
  input  logic                  in_providing_stream,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  out_is_long,
  output logic                  drop_partial,
  output logic                  overflow
);
  import ofdm_rx_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N_FFT - 1);

  logic [ADDR_WIDTH-1:0]   wptr;
  logic [ADDR_WIDTH-1:0]   rptr;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic                    wbank;
  logic                    rbank;
  logic                    discard;
  logic [1:0]              bank_full;
  logic [1:0]              tag;
  r_state_t                r_state;

  logic                    flags_on;
  logic                    accept;
  logic                    wr_en;
  logic                    wr_blocked;
  logic                    wr_last;
  logic                    xfer;
  logic                    rd_last;
  logic                    rbank_ready;
  logic                    other_ready;
  logic [1:0]              set_vec;
  logic [1:0]              clr_vec;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign flags_on   = in_providing_long | in_providing_stream;
  assign accept     = in_strobe & flags_on & ~discard;
  assign wr_blocked = accept & bank_full[wbank];
  assign wr_en      = accept & ~bank_full[wbank];
  assign wr_last    = wr_en & (wptr == LAST);
  assign xfer       = out_valid & out_ready;
  assign rd_last    = xfer & (rptr == LAST);

  // A symbol finishing on this edge counts as already buffered, which gives
  // one-cycle fill-to-valid latency and gap-free back-to-back symbols.
  assign rbank_ready = bank_full[rbank]  | (wr_last & (wbank == rbank));
  assign other_ready = bank_full[~rbank] | (wr_last & (wbank != rbank));

  always_comb begin
    set_vec = 2'b00;
    clr_vec = 2'b00;
    if (wr_last) set_vec[wbank] = 1'b1;
    if (rd_last) clr_vec[rbank] = 1'b1;
  end

`ifdef OFDM_FRAMER_BIT_REVERSE_EN
  assign raddr = bit_reverse(rptr);
`else
  assign raddr = rptr;
`endif

  symbol_pingpong_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_FFT      (N_FFT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .CLK     (CLK),
    .we      (wr_en),
    .wr_bank (wbank),
    .wr_addr (wptr),
    .wr_data ({in_re, in_im}),
    .rd_bank (rbank),
    .rd_addr (raddr),
    .rd_data (rd_data)
  );

  // Write side: fill, tag, partial-symbol discard and overflow recovery.
  always_ff @(posedge CLK) begin
    if (s_RST) begin
      wptr         <= '0;
      wbank        <= 1'b0;
      tag          <= 2'b00;
      bank_full    <= 2'b00;
      discard      <= 1'b0;
      overflow     <= 1'b0;
      drop_partial <= 1'b0;
    end else begin
      drop_partial <= 1'b0;
      if (wr_blocked) begin
        overflow <= 1'b1;
        discard  <= 1'b1;
      end else if (wr_en) begin
        if (wptr == '0) tag[wbank] <= in_providing_long;
        if (wr_last) begin
          wptr  <= '0;
          wbank <= ~wbank;
        end else begin
          wptr <= wptr + 1'b1;
        end
      end else if (!flags_on && (wptr != '0)) begin
        wptr         <= '0;
        drop_partial <= 1'b1;
      end
      // Resume only at a symbol gap with space, so writing re-aligns to sample 0.
      if (discard && !flags_on && !bank_full[wbank]) discard <= 1'b0;
      bank_full <= (bank_full & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge CLK) begin
    if (s_RST) begin
      r_state   <= R_IDLE;
      out_valid <= 1'b0;
      rptr      <= '0;
      rbank     <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rbank_ready) begin
            r_state   <= R_STREAM;
            out_valid <= 1'b1;
          end
        end
        R_STREAM: begin
          if (xfer) begin
            if (rptr == LAST) begin
              rptr  <= '0;
              rbank <= ~rbank;
              if (!other_ready) begin
                r_state   <= R_IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              rptr <= rptr + 1'b1;
            end
          end
        end
        default: begin
          r_state   <= R_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sideband outputs come straight from registered pointers, so they hold during stalls.
  assign out_re      = out_valid ? rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign out_im      = out_valid ? rd_data[DATA_WIDTH-1:0] : '0;
  assign out_index   = out_valid ? raddr : '0;
  assign out_sof     = out_valid & (rptr == '0);
  assign out_eof     = out_valid & (rptr == LAST);
  assign out_is_long = out_valid & tag[rbank];

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Directed self-checking bench for ofdm_symbol_framer (natural or bit-reversed build).
module tb_ofdm_symbol_framer;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  idx;
    logic        sof;
    logic        eof;
    logic        lng;
  } xfer_t;

  logic        CLK = 1'b0;
  logic        s_RST = 1'b1;
  logic        in_strobe = 1'b0;
  logic        in_providing_long = 1'b0;
  logic        in_providing_stream = 1'b0;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [5:0]  out_index;
  logic        out_sof;
  logic        out_eof;
  logic        out_is_long;
  logic        drop_partial;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int drop_cnt = 0;
  xfer_t cap[$];
  int    cap_cyc[$];

  ofdm_symbol_framer dut (
    .CLK                 (CLK),
    .s_RST               (s_RST),
    .in_strobe           (in_strobe),
    .in_providing_long   (in_providing_long),
    .in_providing_stream (in_providing_stream),
    .in_re               (in_re),
    .in_im               (in_im),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_re              (out_re),
    .out_im              (out_im),
    .out_index           (out_index),
    .out_sof             (out_sof),
    .out_eof             (out_eof),
    .out_is_long         (out_is_long),
    .drop_partial        (drop_partial),
    .overflow            (overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int rd_pos(input int k);
    logic [5:0] v;
    logic [5:0] r;
    v = 6'(k);
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
`ifdef OFDM_FRAMER_BIT_REVERSE_EN
    return int'(r);
`else
    return int'(v);
`endif
  endfunction

  function automatic xfer_t exp_xfer(input int k, input int base, input logic lng);
    xfer_t e;
    int pos;
    pos   = rd_pos(k);
    e.re  = 16'(base + pos);
    e.im  = 16'(-(base + pos));
    e.idx = 6'(pos);
    e.sof = (k == 0);
    e.eof = (k == 63);
    e.lng = lng;
    return e;
  endfunction

  function automatic xfer_t now_out();
    xfer_t o;
    o.re  = out_re;
    o.im  = out_im;
    o.idx = out_index;
    o.sof = out_sof;
    o.eof = out_eof;
    o.lng = out_is_long;
    return o;
  endfunction

  // One clock: sample outputs mid-cycle, record transfers, return just after the edge.
  task automatic tick();
    @(negedge CLK);
    if (out_valid && out_ready) begin
      cap.push_back(now_out());
      cap_cyc.push_back(cyc);
    end
    if (drop_partial) drop_cnt++;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    in_strobe = 1'b0;
    in_providing_long = 1'b0;
    in_providing_stream = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic lng, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      in_strobe = 1'b1;
      in_providing_long = lng;
      in_providing_stream = ~lng;
      in_re = 16'(base + k);
      in_im = 16'(-(base + k));
      tick();
    end
    in_strobe = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    for (int c = 0; c < budget && cap.size() < n; c++) tick();
  endtask

  task automatic do_reset();
    s_RST = 1'b1;
    idle(2);
    s_RST = 1'b0;
    cap.delete();
    cap_cyc.delete();
    drop_cnt = 0;
  endtask

  task automatic test_reset();
    s_RST = 1'b1;
    out_ready = 1'b1;
    idle(3);
    n_checks++;
    if ({out_valid, out_sof, out_eof, out_is_long, drop_partial, overflow} !== 6'b0)
      $display("FAIL reset_flags: got %b, required 000000",
               {out_valid, out_sof, out_eof, out_is_long, drop_partial, overflow});
    else n_pass++;
    n_checks++;
    if ({out_re, out_im, out_index} !== 38'h0)
      $display("FAIL reset_data: got %h, required 0", {out_re, out_im, out_index});
    else n_pass++;
    s_RST = 1'b0;
    idle(1);
  endtask

  task automatic test_long_symbol();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 63) begin
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL long_early_valid: got %b, required 0", out_valid);
        else n_pass++;
      end
      in_strobe = 1'b1;
      in_providing_long = 1'b1;
      in_providing_stream = 1'b0;
      in_re = 16'(k);
      in_im = 16'(-k);
      tick();
    end
    in_strobe = 1'b0;
    in_providing_long = 1'b0;
    #3;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL long_fill_latency: out_valid %b, required 1", out_valid);
    else n_pass++;
    collect(64, 200);
    n_checks++;
    if (cap.size() != 64) $display("FAIL long_count: got %0d transfers, required 64", cap.size());
    else n_pass++;
    for (int k = 0; k < 64 && k < cap.size(); k++) begin
      n_checks++;
      if (cap[k] !== exp_xfer(k, 0, 1'b1))
        $display("FAIL long_sample[%0d]: got %h, required %h", k, cap[k], exp_xfer(k, 0, 1'b1));
      else n_pass++;
    end
    idle(2);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL long_idle_after: out_valid %b, required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 0, 64);
    send(1'b0, 100, 64);
    idle(1);
    collect(128, 300);
    n_checks++;
    if (cap.size() != 128) $display("FAIL b2b_count: got %0d transfers, required 128", cap.size());
    else n_pass++;
    if (cap.size() == 128) begin
      n_checks++;
      if (cap_cyc[127] - cap_cyc[0] != 127)
        $display("FAIL b2b_contig: span %0d cycles, required 127", cap_cyc[127] - cap_cyc[0]);
      else n_pass++;
      for (int i = 0; i < 128; i++) begin
        n_checks++;
        if (cap[i] !== exp_xfer(i % 64, (i < 64) ? 0 : 100, i < 64))
          $display("FAIL b2b_sample[%0d]: got %h, required %h", i, cap[i],
                   exp_xfer(i % 64, (i < 64) ? 0 : 100, i < 64));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    logic [41:0] snap;
    logic [41:0] cur;
    logic        stalled;
    do_reset();
    out_ready = 1'b0;
    send(1'b0, 200, 64);
    idle(1);
    stalled = 1'b0;
    snap = '0;
    for (int c = 0; c < 400 && cap.size() < 64; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      @(negedge CLK);
      cur = {out_valid, now_out()};
      if (stalled) begin
        n_checks++;
        if (cur !== snap) $display("FAIL stall_hold c%0d: got %h, required %h", c, cur, snap);
        else n_pass++;
      end
      if (out_valid && out_ready) cap.push_back(now_out());
      stalled = out_valid && !out_ready;
      snap = cur;
      @(posedge CLK);
      #1;
    end
    out_ready = 1'b1;
    n_checks++;
    if (cap.size() != 64) $display("FAIL stall_count: got %0d transfers, required 64", cap.size());
    else n_pass++;
    for (int k = 0; k < 64 && k < cap.size(); k++) begin
      n_checks++;
      if (cap[k] !== exp_xfer(k, 200, 1'b0))
        $display("FAIL stall_sample[%0d]: got %h, required %h", k, cap[k], exp_xfer(k, 200, 1'b0));
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    send(1'b1, 300, 64);
    send(1'b0, 400, 64);
    for (int k = 0; k < 64; k++) begin
      if (k <= 1) begin
        n_checks++;
        if (overflow !== (k == 1))
          $display("FAIL ovf_flag_k%0d: got %b, required %b", k, overflow, (k == 1));
        else n_pass++;
      end
      in_strobe = 1'b1;
      in_providing_long = 1'b0;
      in_providing_stream = 1'b1;
      in_re = 16'(500 + k);
      in_im = 16'(-(500 + k));
      tick();
    end
    idle(3);
    out_ready = 1'b1;
    collect(128, 400);
    idle(20);
    n_checks++;
    if (cap.size() != 128) $display("FAIL ovf_count: got %0d transfers, required 128", cap.size());
    else n_pass++;
    for (int i = 0; i < 128 && i < cap.size(); i++) begin
      n_checks++;
      if (cap[i] !== exp_xfer(i % 64, (i < 64) ? 300 : 400, i < 64))
        $display("FAIL ovf_sample[%0d]: got %h, required %h", i, cap[i],
                 exp_xfer(i % 64, (i < 64) ? 300 : 400, i < 64));
      else n_pass++;
    end
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow);
    else n_pass++;
  endtask

  task automatic test_partial();
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 600, 30);
    idle(6);
    n_checks++;
    if (drop_cnt != 1) $display("FAIL partial_pulses: got %0d, required 1", drop_cnt);
    else n_pass++;
    n_checks++;
    if (cap.size() != 0) $display("FAIL partial_no_output: got %0d transfers, required 0", cap.size());
    else n_pass++;
    send(1'b1, 700, 64);
    idle(1);
    collect(64, 200);
    n_checks++;
    if (cap.size() != 64) $display("FAIL partial_next_count: got %0d, required 64", cap.size());
    else n_pass++;
    for (int k = 0; k < 64 && k < cap.size(); k++) begin
      n_checks++;
      if (cap[k] !== exp_xfer(k, 700, 1'b1))
        $display("FAIL partial_sample[%0d]: got %h, required %h", k, cap[k], exp_xfer(k, 700, 1'b1));
      else n_pass++;
    end
    n_checks++;
    if (drop_cnt != 1) $display("FAIL partial_pulses_total: got %0d, required 1", drop_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 0, 64);
    idle(1);
    collect(20, 200);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b, required 1", out_valid);
    else n_pass++;
    s_RST = 1'b1;
    @(posedge CLK);
    #1;
    s_RST = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b, required 0", out_valid);
    else n_pass++;
    cap.delete();
    idle(80);
    n_checks++;
    if (cap.size() != 0) $display("FAIL rstmid_no_output: got %0d transfers, required 0", cap.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_long_symbol();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_partial();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ofdm_symbol_framer.md
Name: ofdm_symbol_framer

Overview:
- Sits directly downstream of the long-preamble sync FSM and upstream of the 64-point FFT.
- Captures the CP-stripped, phase-corrected samples that sync-long strobes out during its Providing_Long and Providing_Stream windows.
- Packs them into 64-sample symbols in a ping-pong buffer and streams each complete symbol to the FFT over a valid/ready handshake, tagged as long-training or data.

Parameters:
- DATA_WIDTH, 16, width of each I and Q sample (two's complement).
- N_FFT, 64, samples per symbol; must be a power of 2.
- ADDR_WIDTH, 6, log2(N_FFT).

Ports:
- CLK  in  1  clock.
- s_RST  in  1  synchronous, active-high reset.
- in_strobe  in  1  sample-valid from sync-long (Out_Strobe).
- in_providing_long  in  1  sync-long is emitting a long-training symbol.
- in_providing_stream  in  1  sync-long is emitting a data symbol.
- in_re  in  DATA_WIDTH  sample I.
- in_im  in  DATA_WIDTH  sample Q.
- out_valid  out  1  output sample valid.
- out_ready  in  1  FFT accepts the sample.
- out_re  out  DATA_WIDTH  output I.
- out_im  out  DATA_WIDTH  output Q.
- out_index  out  ADDR_WIDTH  index of the sample within its symbol.
- out_sof  out  1  first sample of a symbol (qualified by out_valid).
- out_eof  out  1  last sample of a symbol (qualified by out_valid).
- out_is_long  out  1  current symbol is long training.
- drop_partial  out  1  one-cycle pulse: a partial symbol was discarded.
- overflow  out  1  sticky flag: a sample was dropped because both banks were full.

Behaviour:
- Reset: all outputs 0; wptr=0, rptr=0, wbank=0, rbank=0, both bank_full=0, discard=0, read FSM in R_IDLE.
- Accept condition: in_strobe & (in_providing_long | in_providing_stream) & ~discard. An accepted sample is written on that CLK edge to bank[wbank][wptr], then wptr increments.
- Tag latch: on the write with wptr==0, tag[wbank] <= in_providing_long.
- Symbol complete: on the write with wptr==N_FFT-1, set bank_full[wbank]=1, toggle wbank, and wrap wptr to 0.
- Partial symbol: if both providing flags are low while wptr!=0, set wptr=0 and pulse drop_partial for one cycle. The bank is not marked full.
- Overflow: if an accept condition occurs while bank_full[wbank]=1, drop the sample, set overflow=1 (held until reset), and set discard=1. Clear discard on the first cycle with both flags low and bank_full[wbank]=0, so writing re-aligns to a symbol boundary.
- Read FSM R_IDLE: if bank_full[rbank], go to R_STREAM. out_valid asserts the cycle after the write of sample N_FFT-1 (one-cycle fill-to-valid latency).
- Read FSM R_STREAM: out_valid=1; out_re/out_im = bank[rbank][raddr] via asynchronous read of the register array; out_index=raddr; out_sof=(rptr==0); out_eof=(rptr==N_FFT-1); out_is_long=tag[rbank].
- Handshake: a transfer occurs when out_valid & out_ready, and rptr then increments. If out_ready is low, all outputs hold stable. out_valid never drops mid-symbol.
- End of symbol: on the transfer with rptr==N_FFT-1, clear bank_full[rbank], toggle rbank, and wrap rptr to 0. If the other bank is already full, stay in R_STREAM (zero-bubble, back-to-back symbols); otherwise go to R_IDLE.
- Simultaneous set/clear: set and clear of bank_full on different banks in the same cycle are both honoured. Set and clear of the same bank in the same cycle cannot occur, because wbank != rbank whenever a bank is being read while the other fills.
- Reset mid-operation: every pointer, flag and state returns to its reset value on the next edge. Buffered data is abandoned; the contents need not be cleared.

Optional Feature:
- Macro: OFDM_FRAMER_BIT_REVERSE_EN.
- Defined: raddr = bit-reverse(rptr) over ADDR_WIDTH bits, so the FFT receives samples in bit-reversed order. out_index reports raddr. out_sof/out_eof still mark the first and last transfers.
- Undefined: raddr = rptr (natural order).

Decomposition:
- Package ofdm_rx_pkg holds:
  - N_FFT, ADDR_WIDTH, DATA_WIDTH constants;
  - read-FSM state typedef (R_IDLE, R_STREAM);
  - bit_reverse function.
- Sub-module symbol_pingpong_ram holds the 2×N_FFT×(2·DATA_WIDTH) register array: one synchronous write port (bank, addr, data, we) and one asynchronous read port (bank, addr).
- Top level holds the write control, discard/overflow logic and the read FSM.

Test Plan:
- Long symbol, ready held high: 64 accepted strobes with in_providing_long=1, in_re=k, in_im=-k for k=0..63 → out_valid rises the cycle after k=63; 64 transfers with out_re=0..63; out_sof on the first, out_eof on the last; out_is_long=1.
- Back-to-back: one long symbol then one stream symbol with out_ready=1 → 128 contiguous transfers with no out_valid gap; out_is_long goes 1 then 0.
- Stall: out_ready toggled 1,0,0,1,… → outputs stable during stalls; all 64 values delivered in order with none lost or duplicated.
- Overflow: out_ready=0, three full symbols sent → overflow=1 on sample 0 of the third symbol; third symbol dropped; after raising out_ready, the first two symbols are output intact.
- Partial: flags drop after 30 samples → drop_partial pulses once, no output; the next 64-sample symbol is output with out_re starting at its own sample 0.
- Reset/bit-reverse: s_RST asserted at output sample 20 → out_valid=0 the next cycle and no further output. With OFDM_FRAMER_BIT_REVERSE_EN defined, the ramp symbol outputs out_re=0,32,16,48,…
